// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
package hazard_ctrl_pkg;

    localparam int unsigned AWIDTH = 5;
    localparam int unsigned SWIDTH = 2;

    typedef enum logic [SWIDTH-1:0] {
        HC_RUN   = 2'd0,
        HC_STALL = 2'd1,
        HC_WAIT  = 2'd2
    } hc_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX load whose nonzero destination feeds a source read in decode.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [AWIDTH-1:0] addr_rs1,
    input  logic [AWIDTH-1:0] addr_rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              memread,
    input  logic [AWIDTH-1:0] addr_rd,
    output logic              lu_c
);

    logic rd_nz;
    logic hit_rs1;
    logic hit_rs2;

    // $0 is hardwired to zero, so a load targeting it never creates a dependency
    assign rd_nz   = (addr_rd != AWIDTH'(0));
    assign hit_rs1 = use_rs1 && (addr_rs1 == addr_rd);
    assign hit_rs2 = use_rs2 && (addr_rs2 == addr_rd);
    assign lu_c    = memread && rd_nz && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: load-use bubble, branch squash, memory freeze with
// deferred branch flush, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] ds_i_addr_rs1,
    input  logic [AWIDTH-1:0] ds_i_addr_rs2,
    input  logic              ds_i_use_rs1,
    input  logic              ds_i_use_rs2,
    input  logic              ds_es_i_memread,
    input  logic [AWIDTH-1:0] ds_es_i_addr_rd,
    input  logic              es_i_branch_taken,
    input  logic              ms_i_mem_busy,
    input  logic              i_cnt_clr,
    output logic              o_pc_en,
    output logic              o_fs_ds_en,
    output logic              o_ds_es_en,
    output logic              o_es_ms_en,
    output logic              o_ms_wb_en,
    output logic              o_fs_ds_flush,
    output logic              o_ds_es_flush,
    output logic [SWIDTH-1:0] o_state,
    output logic [CWIDTH-1:0] o_stall_cnt
);

    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

    hc_state_e         state;
    hc_state_e         state_next;
    logic              pend;
    logic              pend_next;
    logic              lu_c;
    logic              branch_c;
    logic              pc_en_c;
    logic              fs_ds_en_c;
    logic              ds_es_en_c;
    logic              es_ms_en_c;
    logic              ms_wb_en_c;
    logic              fs_ds_flush_c;
    logic              ds_es_flush_c;
    logic [CWIDTH-1:0] cnt;

    hazard_detect u_detect (
        .addr_rs1 (ds_i_addr_rs1),
        .addr_rs2 (ds_i_addr_rs2),
        .use_rs1  (ds_i_use_rs1),
        .use_rs2  (ds_i_use_rs2),
        .memread  (ds_es_i_memread),
        .addr_rd  (ds_es_i_addr_rd),
        .lu_c     (lu_c)
    );

    assign branch_c = es_i_branch_taken || pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HC_RUN;
            pend  <= 1'b0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
        end
    end

    // Freeze beats branch beats load-use; STALL ignores lu to cap the bubble at one
    always_comb begin
        state_next    = state;
        pend_next     = pend;
        pc_en_c       = 1'b1;
        fs_ds_en_c    = 1'b1;
        ds_es_en_c    = 1'b1;
        es_ms_en_c    = 1'b1;
        ms_wb_en_c    = 1'b1;
        fs_ds_flush_c = 1'b0;
        ds_es_flush_c = 1'b0;

        if (ms_i_mem_busy) begin
            pc_en_c    = 1'b0;
            fs_ds_en_c = 1'b0;
            ds_es_en_c = 1'b0;
            es_ms_en_c = 1'b0;
            ms_wb_en_c = 1'b0;
            pend_next  = pend || es_i_branch_taken;
            state_next = HC_WAIT;
        end else begin
            pend_next  = 1'b0;
            state_next = HC_RUN;
            case (state)
                HC_STALL: begin
                    if (branch_c) begin
                        fs_ds_flush_c = 1'b1;
                        ds_es_flush_c = 1'b1;
                    end
                end
                default: begin
                    if (branch_c) begin
                        fs_ds_flush_c = 1'b1;
                        ds_es_flush_c = 1'b1;
                    end else if (lu_c) begin
                        pc_en_c       = 1'b0;
                        fs_ds_en_c    = 1'b0;
                        ds_es_flush_c = 1'b1;
                        state_next    = HC_STALL;
                    end
                end
            endcase
        end
    end

    // Reset holds every enable and flush low, independent of the clock
    assign o_pc_en       = pc_en_c       && rst_n;
    assign o_fs_ds_en    = fs_ds_en_c    && rst_n;
    assign o_ds_es_en    = ds_es_en_c    && rst_n;
    assign o_es_ms_en    = es_ms_en_c    && rst_n;
    assign o_ms_wb_en    = ms_wb_en_c    && rst_n;
    assign o_fs_ds_flush = fs_ds_flush_c && rst_n;
    assign o_ds_es_flush = ds_es_flush_c && rst_n;
    assign o_state       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (i_cnt_clr) begin
            cnt <= '0;
        end else if (!pc_en_c && (cnt != CNT_MAX)) begin
            cnt <= cnt + CWIDTH'(1);
        end
    end

    assign o_stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; a second instance with a 2-bit counter covers saturation.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [6:0] EN_ALL   = 7'b1111100;
    localparam logic [6:0] STALL_LU = 7'b0011101;
    localparam logic [6:0] BRANCH   = 7'b1111111;
    localparam logic [6:0] FREEZE   = 7'b0000000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AWIDTH-1:0] rs1, rs2, rd;
    logic              u1, u2, mr, bt, busy, clr;

    logic        pc_en, fs_ds_en, ds_es_en, es_ms_en, ms_wb_en, fs_fl, ds_fl;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        s_pc_en, s_fs_ds_en, s_ds_es_en, s_es_ms_en, s_ms_wb_en, s_fs_fl, s_ds_fl;
    logic [1:0]  s_st;
    logic [1:0]  s_cnt;

    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt;
    logic [1:0]  exp_cnt_s;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ds_i_addr_rs1(rs1), .ds_i_addr_rs2(rs2),
        .ds_i_use_rs1(u1), .ds_i_use_rs2(u2),
        .ds_es_i_memread(mr), .ds_es_i_addr_rd(rd),
        .es_i_branch_taken(bt), .ms_i_mem_busy(busy), .i_cnt_clr(clr),
        .o_pc_en(pc_en), .o_fs_ds_en(fs_ds_en), .o_ds_es_en(ds_es_en),
        .o_es_ms_en(es_ms_en), .o_ms_wb_en(ms_wb_en),
        .o_fs_ds_flush(fs_fl), .o_ds_es_flush(ds_fl),
        .o_state(st), .o_stall_cnt(cnt)
    );

    hazard_ctrl #(.CWIDTH(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .ds_i_addr_rs1(rs1), .ds_i_addr_rs2(rs2),
        .ds_i_use_rs1(u1), .ds_i_use_rs2(u2),
        .ds_es_i_memread(mr), .ds_es_i_addr_rd(rd),
        .es_i_branch_taken(bt), .ms_i_mem_busy(busy), .i_cnt_clr(clr),
        .o_pc_en(s_pc_en), .o_fs_ds_en(s_fs_ds_en), .o_ds_es_en(s_ds_es_en),
        .o_es_ms_en(s_es_ms_en), .o_ms_wb_en(s_ms_wb_en),
        .o_fs_ds_flush(s_fs_fl), .o_ds_es_flush(s_ds_fl),
        .o_state(s_st), .o_stall_cnt(s_cnt)
    );

    function automatic logic [6:0] ctl_vec();
        return {pc_en, fs_ds_en, ds_es_en, es_ms_en, ms_wb_en, fs_fl, ds_fl};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive one cycle at negedge, queue its expectation, then compare mid-cycle
    task automatic step(input string tag,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic e1, input logic e2, input logic ld,
                        input logic [4:0] d, input logic b, input logic bz, input logic c,
                        input logic [6:0] ectl, input logic [1:0] est);
        exp_t e;
        @(negedge clk);
        rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; mr = ld; rd = d;
        bt = b; busy = bz; clr = c;
        e.tag = tag; e.ctl = ectl; e.st = est; e.cnt = exp_cnt; e.cnt_s = exp_cnt_s;
        sb.push_back(e);
        if (c) begin
            exp_cnt = '0; exp_cnt_s = '0;
        end else if (!ectl[6]) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (exp_cnt_s != 2'd3)   exp_cnt_s = exp_cnt_s + 2'd1;
        end
        #2;
        e = sb.pop_front();
        check({e.tag, ".ctl"},   32'(ctl_vec()), 32'(e.ctl));
        check({e.tag, ".state"}, 32'(st),        32'(e.st));
        check({e.tag, ".cnt"},   32'(cnt),       32'(e.cnt));
        check({e.tag, ".cnt2"},  32'(s_cnt),     32'(e.cnt_s));
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0; bt = 1'b0; busy = 1'b0; clr = 1'b0;
        exp_cnt = '0; exp_cnt_s = '0;
        #2;
        check("reset.ctl",   32'(ctl_vec()), 32'(FREEZE));
        check("reset.state", 32'(st),        32'(HC_RUN));
        check("reset.cnt",   32'(cnt),       32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_RUN);
        step("lu_rs1",    5, 0, 1, 0, 1, 5, 0, 0, 0, STALL_LU, HC_RUN);
        step("lu_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_STALL);
        step("lu_resume", 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_RUN);
        step("rd_zero",   0, 0, 1, 0, 1, 0, 0, 0, 0, EN_ALL,   HC_RUN);
        step("unused_rs2",3, 7, 1, 0, 1, 7, 0, 0, 0, EN_ALL,   HC_RUN);
        step("lu_rs2",    0, 9, 0, 1, 1, 9, 0, 0, 0, STALL_LU, HC_RUN);
        step("b2b_load",  0, 9, 0, 1, 1, 9, 0, 0, 0, EN_ALL,   HC_STALL);
        step("br_vs_lu",  5, 0, 1, 0, 1, 5, 1, 0, 0, BRANCH,   HC_RUN);
        step("br_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_RUN);

        step("wait1_br",  0, 0, 0, 0, 0, 0, 1, 1, 0, FREEZE,   HC_RUN);
        step("wait2",     0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE,   HC_WAIT);
        step("wait3",     0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE,   HC_WAIT);
        step("wait_exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, BRANCH,   HC_WAIT);
        step("wait_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_RUN);

        step("wlu_busy",  0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE,   HC_RUN);
        step("wlu_exit",  4, 0, 1, 0, 1, 4, 0, 0, 0, STALL_LU, HC_WAIT);
        step("wlu_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_STALL);
        step("stall_br",  0, 0, 0, 0, 0, 0, 1, 0, 0, BRANCH,   HC_RUN);

        step("lu_clr",    6, 0, 1, 0, 1, 6, 0, 0, 1, STALL_LU, HC_RUN);
        step("clr_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_STALL);
        step("lu_again",  6, 0, 1, 0, 1, 6, 0, 0, 0, STALL_LU, HC_RUN);
        step("lu_again2", 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_STALL);

        step("rw_busy_br",0, 0, 0, 0, 0, 0, 1, 1, 0, FREEZE,   HC_RUN);
        step("rw_busy",   0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE,   HC_WAIT);
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0; exp_cnt_s = '0;
        check("rst_mid.ctl",   32'(ctl_vec()), 32'(FREEZE));
        check("rst_mid.state", 32'(st),        32'(HC_RUN));
        check("rst_mid.cnt",   32'(cnt),       32'd0);
        check("rst_mid.cnt2",  32'(s_cnt),     32'd0);
        @(negedge clk);
        busy = 1'b0; bt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("rw_resume", 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_RUN);
        step("rw_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL,   HC_RUN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core, working alongside the forwarding unit. It detects load-use hazards that forwarding cannot cover and inserts one bubble. It squashes wrong-path instructions on a taken branch and freezes the whole pipeline while data memory is busy, remembering a branch flush raised during the freeze. It drives the PC enable, the pipeline-register enables and flushes, and a saturating stall-cycle counter.

## Interface
- AWIDTH, 5: register address width (same value as the shared header).
- CWIDTH, 16: stall counter width.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ds_i_addr_rs1, ds_i_addr_rs2  in  AWIDTH  source registers of the instruction in decode.
- ds_i_use_rs1, ds_i_use_rs2  in  1  decode instruction actually reads rs1 / rs2.
- ds_es_i_memread  in  1  instruction in EX is a load.
- ds_es_i_addr_rd  in  AWIDTH  destination register of the instruction in EX.
- es_i_branch_taken  in  1  branch or jump resolved taken in EX.
- ms_i_mem_busy  in  1  data memory not ready this cycle.
- i_cnt_clr  in  1  synchronous clear of the stall counter.
- o_pc_en  out  1  PC update enable.
- o_fs_ds_en, o_ds_es_en, o_es_ms_en, o_ms_wb_en  out  1  pipeline register enables.
- o_fs_ds_flush, o_ds_es_flush  out  1  load a bubble into IF/ID and ID/EX.
- o_state  out  2  current state (RUN=0, STALL=1, WAIT=2).
- o_stall_cnt  out  CWIDTH  count of cycles with o_pc_en=0, saturating.

## Operation
- Load-use hazard (lu) is asserted when all of the following hold:
  - ds_es_i_memread=1.
  - ds_es_i_addr_rd is nonzero.
  - ds_es_i_addr_rd matches a used rs1 or rs2.
- The state is RUN, STALL or WAIT; pend is a 1-bit register.
- Priority each cycle: mem_busy > branch (es_i_branch_taken OR pend) > lu.
- Default outputs: all enables 1, flushes 0.
- RUN:
  - mem_busy: all enables 0, flushes 0. pend <= pend OR es_i_branch_taken. Next state WAIT.
  - branch: o_fs_ds_flush=1 and o_ds_es_flush=1; enables stay 1. pend <= 0. Next state RUN.
  - lu: o_pc_en=0, o_fs_ds_en=0, o_ds_es_flush=1. Next state STALL.
  - Otherwise: stay in RUN.
- STALL: same as RUN, except lu is ignored, which caps a load-use stall at one bubble. Without mem_busy, the next state is RUN.
- WAIT:
  - While mem_busy=1: all enables 0, flushes 0. pend <= pend OR es_i_branch_taken. Stay in WAIT.
  - On the first cycle with mem_busy=0 (exit cycle): behave exactly as RUN, using branch = es_i_branch_taken OR pend. Clear pend and leave for the resulting next state.
- A branch flush overrides lu in the same cycle: the load's dependent instruction is squashed, so no bubble is needed.
- Counter:
  - Increments every cycle o_pc_en=0.
  - Holds at 2^CWIDTH-1.
  - i_cnt_clr wins over increment: the next value is 0.
- Reset:
  - Asynchronous clear: state=RUN, pend=0, o_stall_cnt=0.
  - While rst_n=0, all enables and flushes are forced to 0 and o_state=0.
  - Reset in mid-WAIT discards pend.

## Timing
- Enables and flushes are combinational from the current state and inputs, and are valid in the same cycle. No input-to-output register is allowed.
- State, pend and counter update on the rising edge of clk.
- Load-use costs exactly 1 cycle: o_pc_en is low for 1 cycle and one bubble is inserted into ID/EX.
- Taken branch costs 2 squashed slots, flushed in the EX-resolve cycle.
- Memory wait of N busy cycles:
  - o_pc_en is low for N cycles.
  - A pending flush fires in the exit cycle, never earlier.
- Back-to-back loads with lu in the STALL cycle produce no second bubble.
- o_stall_cnt reflects a stalled cycle one edge later.

## Structure
- The shared header holds AWIDTH and the state encodings `HC_RUN`, `HC_STALL` and `HC_WAIT`.
- The counter saturation constant is derived locally from CWIDTH.
- One sub-module, `hazard_detect`, is combinational. It holds the lu comparator with rd≠0 gating and the use-bit qualification.
- The FSM, pend and counter live in `hazard_ctrl`.

## Test plan
- Load-use:
  - Stimulus: EX is lw with rd=5; decode rs1=5, use_rs1=1.
  - Response: 1 cycle with o_pc_en=0, o_fs_ds_en=0, o_ds_es_flush=1, o_state=1 on the next cycle, then normal run; counter=1.
- Register $0 and unused source:
  - Stimulus: lw with rd=0 and rs1=0. Separately, rd=7 and rs2=7 with use_rs2=0.
  - Response: no stall in either case.
- Taken branch:
  - Stimulus: es_i_branch_taken=1 together with lu true.
  - Response: both flushes=1 and o_pc_en=1; no stall; state stays RUN.
- Memory wait with pending branch:
  - Stimulus: mem_busy high for 3 cycles, with branch_taken pulsed in the first.
  - Response: 3 cycles of all enables=0 with no flush. The exit cycle has both flushes=1. Counter=3.
- Reset in mid-WAIT:
  - Stimulus: assert rst_n=0 asynchronously between edges.
  - Response: outputs go to 0 immediately; after release, o_state=0, counter=0 and pend cleared (no flush on resume).
- Counter:
  - Stimulus: run with CWIDTH=2 and hold mem_busy for 5 cycles; then assert i_cnt_clr during a stall.
  - Response: counter saturates at 3; the clear gives 0 on the next edge.
